// File: rtl/parity_ram.sv
// Single-port RAM that stores an even-parity bit with each word. Reads are
// registered and checked for parity; a saturating counter tallies bad reads.
module parity_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  inject_err,
    output logic [DATA_WIDTH:0]   data_out,
    output logic                  valid_out,
    output logic                  par_err,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [DATA_WIDTH:0]   rd_word;
    logic                  rd_mismatch;
    logic                  do_read;

    assign rd_word     = mem[address];
    assign rd_mismatch = rd_word[DATA_WIDTH] != (^rd_word[DATA_WIDTH-1:0]);
    assign do_read     = (state == READY) && read && !write;

    // NOTE: the array has no reset branch; the CLEAR walk initialises it,
    // which keeps the storage mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (write) begin
                mem[address] <= {(^data_in) ^ inject_err, data_in};
            end
        end
    end

    // Control, read path and error counter; rst wins over any strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            busy      <= 1'b1;
            data_out  <= '0;
            valid_out <= 1'b0;
            par_err   <= 1'b0;
            err_count <= '0;
        end else begin
            valid_out <= 1'b0;
            par_err   <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (do_read) begin
                        data_out  <= rd_word;
                        valid_out <= 1'b1;
                        par_err   <= rd_mismatch;
                        if (rd_mismatch && (err_count != '1)) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_ram.sv
// Directed bench: a 16-word/2-bit-counter instance covers clear, saturation and
// reset cases; a default-sized instance covers the 16-bit address scenarios.
module tb_parity_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_rst;
    logic        write;
    logic        read;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        inject_err;

    logic [8:0]  data_out;
    logic        valid_out;
    logic        par_err;
    logic [7:0]  err_count;
    logic        busy;

    logic [8:0]  s_data_out;
    logic        s_valid_out;
    logic        s_par_err;
    logic [1:0]  s_err_count;
    logic        s_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    parity_ram dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
        .inject_err (inject_err),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .par_err    (par_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    parity_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(2)) dut_small (
        .clk        (clk),
        .rst        (s_rst),
        .write      (write),
        .read       (read),
        .address    (address[3:0]),
        .data_in    (data_in),
        .inject_err (inject_err),
        .data_out   (s_data_out),
        .valid_out  (s_valid_out),
        .par_err    (s_par_err),
        .err_count  (s_err_count),
        .busy       (s_busy)
    );

    // Drive strobes at the falling edge, sample 1 ns after the rising edge.
    task automatic cycle(input logic w, input logic r, input logic [15:0] a,
                         input logic [7:0] d, input logic inj);
        @(negedge clk);
        write      = w;
        read       = r;
        address    = a;
        data_in    = d;
        inject_err = inj;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    // Pulse s_rst, then count falling edges with busy high.
    task automatic small_reset_count(output int n);
        @(negedge clk);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!s_busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        write = 1'b0; read = 1'b0; address = '0; data_in = '0; inject_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 9'h000 || valid_out !== 1'b0 || par_err !== 1'b0 ||
            err_count !== 8'h00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_big: got do=%h v=%b pe=%b cnt=%h busy=%b, want 000 0 0 00 1",
                     data_out, valid_out, par_err, err_count, busy);
        end
        checks++;
        if (s_data_out !== 9'h000 || s_valid_out !== 1'b0 || s_par_err !== 1'b0 ||
            s_err_count !== 2'd0 || s_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_small: got do=%h v=%b pe=%b cnt=%0d busy=%b, want 000 0 0 0 1",
                     s_data_out, s_valid_out, s_par_err, s_err_count, s_busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        // Pollute memory first is impossible while busy; the strobe must be ignored.
        small_reset_count(n);
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL clear_busy_cycles: got %0d, want 16", n);
        end
        for (int a = 0; a < 16; a++) begin
            cycle(1'b0, 1'b1, 16'(a), 8'h00, 1'b0);
            checks++;
            if (s_data_out !== 9'h000 || s_valid_out !== 1'b1 || s_par_err !== 1'b0) begin
                failures++;
                $display("FAIL clear_read[%0d]: got do=%h v=%b pe=%b, want 000 1 0",
                         a, s_data_out, s_valid_out, s_par_err);
            end
        end
        idle();
        checks++;
        if (s_valid_out !== 1'b0 || s_err_count !== 2'd0) begin
            failures++;
            $display("FAIL clear_idle: got v=%b cnt=%0d, want 0 0", s_valid_out, s_err_count);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 16'(i + 1), 8'h01, 1'b1);
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 16'(i + 1), 8'h00, 1'b0);
            checks++;
            if (s_data_out !== 9'h001 || s_par_err !== 1'b1 || s_valid_out !== 1'b1 ||
                s_err_count !== exp_cnt[i]) begin
                failures++;
                $display("FAIL saturation[%0d]: got do=%h pe=%b v=%b cnt=%0d, want 001 1 1 %0d",
                         i, s_data_out, s_par_err, s_valid_out, s_err_count, exp_cnt[i]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int n;
        // Reset after 7 clear cycles must restart the full walk.
        @(negedge clk);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        repeat (7) @(negedge clk);
        small_reset_count(n);
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL reset_mid_clear: busy cycles got %0d, want 16", n);
        end
        cycle(1'b1, 1'b0, 16'h0003, 8'h3C, 1'b1);
        cycle(1'b0, 1'b1, 16'h0003, 8'h00, 1'b0);
        checks++;
        if (s_valid_out !== 1'b1 || s_par_err !== 1'b1 || s_err_count !== 2'd1 ||
            s_data_out !== 9'h13C) begin
            failures++;
            $display("FAIL reset_mid_read_pre: got do=%h v=%b pe=%b cnt=%0d, want 13c 1 1 1",
                     s_data_out, s_valid_out, s_par_err, s_err_count);
        end
        // Read still asserted during the reset edge: its result must be discarded.
        @(negedge clk);
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_valid_out !== 1'b0 || s_err_count !== 2'd0 || s_busy !== 1'b1 ||
            s_data_out !== 9'h000) begin
            failures++;
            $display("FAIL reset_mid_read: got v=%b cnt=%0d busy=%b do=%h, want 0 0 1 000",
                     s_valid_out, s_err_count, s_busy, s_data_out);
        end
        @(negedge clk);
        s_rst = 1'b0;
        read  = 1'b0;
    endtask

    task automatic wait_big_ready();
        int n = 0;
        while (busy === 1'b1 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL big_clear_timeout: busy=%b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic test_write_read();
        cycle(1'b1, 1'b0, 16'h1234, 8'hA5, 1'b0);
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL write_no_valid: got %b, want 0", valid_out);
        end
        cycle(1'b1, 1'b0, 16'hFFFF, 8'h07, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 8'h00, 1'b0);
        checks++;
        if (data_out !== 9'h0A5 || valid_out !== 1'b1 || par_err !== 1'b0) begin
            failures++;
            $display("FAIL read_1234: got do=%h v=%b pe=%b, want 0a5 1 0",
                     data_out, valid_out, par_err);
        end
        idle();
        checks++;
        if (valid_out !== 1'b0 || data_out !== 9'h0A5) begin
            failures++;
            $display("FAIL read_hold: got v=%b do=%h, want 0 0a5", valid_out, data_out);
        end
        cycle(1'b0, 1'b1, 16'hFFFF, 8'h00, 1'b0);
        checks++;
        if (data_out !== 9'h107 || valid_out !== 1'b1 || par_err !== 1'b0 ||
            err_count !== 8'h00) begin
            failures++;
            $display("FAIL read_ffff: got do=%h v=%b pe=%b cnt=%h, want 107 1 0 00",
                     data_out, valid_out, par_err, err_count);
        end
        idle();
    endtask

    task automatic test_inject();
        cycle(1'b1, 1'b0, 16'h0010, 8'h3C, 1'b1);
        cycle(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0);
        checks++;
        if (data_out !== 9'h13C || par_err !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL inject_read: got do=%h pe=%b cnt=%0d, want 13c 1 1",
                     data_out, par_err, err_count);
        end
        idle();
        checks++;
        if (par_err !== 1'b0 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL inject_idle: got pe=%b cnt=%0d, want 0 1", par_err, err_count);
        end
        cycle(1'b1, 1'b0, 16'h0010, 8'h3C, 1'b0);
        cycle(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0);
        checks++;
        if (data_out !== 9'h03C || par_err !== 1'b0 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL rewrite_read: got do=%h pe=%b cnt=%0d, want 03c 0 1",
                     data_out, par_err, err_count);
        end
        idle();
    endtask

    task automatic test_collision();
        cycle(1'b1, 1'b1, 16'h0020, 8'h81, 1'b0);
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL collision_valid: got %b, want 0", valid_out);
        end
        idle();
        cycle(1'b0, 1'b1, 16'h0020, 8'h00, 1'b0);
        checks++;
        if (data_out !== 9'h081 || valid_out !== 1'b1 || par_err !== 1'b0) begin
            failures++;
            $display("FAIL collision_read: got do=%h v=%b pe=%b, want 081 1 0",
                     data_out, valid_out, par_err);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [3] = '{16'h1234, 16'hFFFF, 16'h0010};
        logic [8:0]  exp   [3] = '{9'h0A5, 9'h107, 9'h03C};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, addrs[i], 8'h00, 1'b0);
            checks++;
            if (data_out !== exp[i] || valid_out !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got do=%h v=%b, want %h 1",
                         i, data_out, valid_out, exp[i]);
            end
        end
        idle();
        checks++;
        if (valid_out !== 1'b0 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL back_to_back_end: got v=%b cnt=%0d, want 0 1", valid_out, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_saturation();
        test_reset_mid();
        wait_big_ready();
        test_write_read();
        test_inject();
        test_collision();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
